// File: rtl/qspi_read_master.sv
// Quad-SPI NOR read initiator: 0xEB command, 24-bit address, dummy cycles, then 1/2/4 data bytes on all four lines.
// Latency: rsp_valid pulses 2*(8+DUMMY_CYCLES+2N)+1 cycles after the accept cycle (N = bytes read).
// Backpressure: req_ready is high only in IDLE; one transaction in flight, csb held high CSB_HIGH_CYCLES before next accept.
module qspi_read_master #(
    parameter logic [7:0] CMD             = 8'hEB,
    parameter int         DUMMY_CYCLES    = 10,
    parameter int         CSB_HIGH_CYCLES = 4
) (
    input  logic        sysclk,
    input  logic        sysrst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [1:0]  req_size,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        qspi_sck,
    output logic        qspi_csb,
    output logic [3:0]  qspi_dout,
    output logic [3:0]  qspi_oe,
    input  logic [3:0]  qspi_din
);

    localparam int CW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_FINISH
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;          // sck periods done in the current phase (or FINISH wait cycles)
    logic [23:0]    addr_sh, addr_sh_nxt;  // address, shifted left as nibbles go out
    logic [2:0]     nib_last, nib_last_nxt; // index of the final data nibble
    logic           sck_nxt, csb_nxt, rsp_valid_nxt;
    logic [3:0]     dout_nxt, oe_nxt;
    logic [31:0]    rsp_data_nxt;
    logic [4:0]     data_pos;              // bit offset of the nibble being captured

    // Ready is purely a function of being idle; held low throughout reset.
    assign req_ready = (state == S_IDLE) && !sysrst;

    // State and registered pad outputs.
    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            addr_sh   <= '0;
            nib_last  <= '0;
            qspi_sck  <= 1'b0;
            qspi_csb  <= 1'b1;
            qspi_dout <= 4'h0;
            qspi_oe   <= 4'h0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            addr_sh   <= addr_sh_nxt;
            nib_last  <= nib_last_nxt;
            qspi_sck  <= sck_nxt;
            qspi_csb  <= csb_nxt;
            qspi_dout <= dout_nxt;
            qspi_oe   <= oe_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
        end
    end

    // Next-state logic: LOW phase raises sck (capturing din in DATA); HIGH phase drops sck and advances.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        addr_sh_nxt   = addr_sh;
        nib_last_nxt  = nib_last;
        sck_nxt       = qspi_sck;
        csb_nxt       = qspi_csb;
        dout_nxt      = qspi_dout;
        oe_nxt        = qspi_oe;
        rsp_valid_nxt = 1'b0;
        rsp_data_nxt  = rsp_data;
        // Byte k lands at [8k+7:8k]; the even nibble of each byte is its high half.
        data_pos      = {cnt[2:1], ~cnt[0], 2'b00};

        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    state_nxt    = S_CMD;
                    cnt_nxt      = '0;
                    addr_sh_nxt  = req_addr;
                    case (req_size)
                        2'd0:    nib_last_nxt = 3'd1;
                        2'd1:    nib_last_nxt = 3'd3;
                        default: nib_last_nxt = 3'd7;
                    endcase
                    sck_nxt      = 1'b0;
                    csb_nxt      = 1'b0;
                    oe_nxt       = 4'hF;
                    dout_nxt     = CMD[7:4];
                    rsp_data_nxt = '0;
                end
            end

            S_CMD: begin
                if (!qspi_sck) begin
                    sck_nxt = 1'b1;
                end else begin
                    sck_nxt = 1'b0;
                    if (cnt == CW'(1)) begin
                        state_nxt = S_ADDR;
                        cnt_nxt   = '0;
                        dout_nxt  = addr_sh[23:20];
                    end else begin
                        cnt_nxt  = cnt + CW'(1);
                        dout_nxt = CMD[3:0];
                    end
                end
            end

            S_ADDR: begin
                if (!qspi_sck) begin
                    sck_nxt = 1'b1;
                end else begin
                    sck_nxt = 1'b0;
                    if (cnt == CW'(5)) begin
                        // Bus turnaround: release the lines for the whole dummy phase.
                        state_nxt = S_DUMMY;
                        cnt_nxt   = '0;
                        oe_nxt    = 4'h0;
                        dout_nxt  = 4'h0;
                    end else begin
                        cnt_nxt     = cnt + CW'(1);
                        addr_sh_nxt = {addr_sh[19:0], 4'h0};
                        dout_nxt    = addr_sh[19:16];
                    end
                end
            end

            S_DUMMY: begin
                if (!qspi_sck) begin
                    sck_nxt = 1'b1;
                end else begin
                    sck_nxt = 1'b0;
                    if (cnt == CW'(DUMMY_CYCLES - 1)) begin
                        state_nxt = S_DATA;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end

            S_DATA: begin
                if (!qspi_sck) begin
                    sck_nxt                     = 1'b1;
                    rsp_data_nxt[data_pos +: 4] = qspi_din;
                end else begin
                    sck_nxt = 1'b0;
                    if (cnt == {5'd0, nib_last}) begin
                        state_nxt     = S_FINISH;
                        cnt_nxt       = '0;
                        csb_nxt       = 1'b1;
                        rsp_valid_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end

            S_FINISH: begin
                if (cnt == CW'(CSB_HIGH_CYCLES - 1)) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            default: begin
                state_nxt = S_IDLE;
                sck_nxt   = 1'b0;
                csb_nxt   = 1'b1;
                oe_nxt    = 4'h0;
            end
        endcase
    end

endmodule

// File: tb/tb_qspi_read_master.sv
// Bench for qspi_read_master: behavioural quad flash plus a scoreboard of expected read words.
// Latency: checks accept-to-rsp_valid, csb-low length and sck rise counts per transaction.
// Backpressure: drives req_valid and waits on req_ready, including held-valid back-to-back requests.
module tb_qspi_read_master;

    localparam int DUMMY = 10;
    localparam int CSBH  = 4;

    logic        sysclk = 1'b0;
    logic        sysrst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        qspi_sck, qspi_csb;
    logic [3:0]  qspi_dout, qspi_oe, qspi_din;

    qspi_read_master #(.CMD(8'hEB), .DUMMY_CYCLES(DUMMY), .CSB_HIGH_CYCLES(CSBH)) dut (
        .sysclk(sysclk), .sysrst(sysrst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_size(req_size),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .qspi_sck(qspi_sck), .qspi_csb(qspi_csb),
        .qspi_dout(qspi_dout), .qspi_oe(qspi_oe), .qspi_din(qspi_din)
    );

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge sysclk) cyc++;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- flash model ----------------
    logic [7:0]  mem [0:255];
    int          fr = 0;
    logic [7:0]  f_cmd = '0;
    logic [23:0] f_addr = '0;
    logic        f_drive = 1'b0;
    logic [3:0]  f_nib = '0;
    logic [3:0]  cap_dout [8];
    logic [3:0]  cap_oe [8];

    assign qspi_din = f_drive ? f_nib : 4'h0;

    // New transaction on csb falling.
    always @(negedge qspi_csb) begin
        fr = 0;
        f_drive = 1'b0;
    end

    always @(posedge qspi_csb) f_drive = 1'b0;

    // Flash samples command/address on sck rising.
    always @(posedge qspi_sck) begin
        if (!qspi_csb) begin
            if (fr < 8) begin
                cap_dout[fr] = qspi_dout;
                cap_oe[fr]   = qspi_oe;
            end
            if (fr < 2)      f_cmd  = {f_cmd[3:0], qspi_dout};
            else if (fr < 8) f_addr = {f_addr[19:0], qspi_dout};
            fr++;
        end
    end

    // Flash drives data on sck falling once the dummy periods have elapsed.
    always @(negedge qspi_sck) begin
        int j;
        logic [7:0] b;
        if (qspi_csb) begin
            f_drive = 1'b0;
        end else if (fr >= 8 + DUMMY) begin
            j = fr - (8 + DUMMY);
            b = mem[8'(f_addr[7:0] + 8'(j / 2))];
            f_nib = j[0] ? b[3:0] : b[7:4];
            f_drive = 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q [$];
    logic [31:0] rsp_hist [$];

    function automatic logic [31:0] exp_word(input logic [23:0] a, input logic [1:0] s);
        logic [31:0] w;
        int n;
        w = '0;
        n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        for (int k = 0; k < n; k++) w[8*k +: 8] = mem[8'(a[7:0] + 8'(k))];
        return w;
    endfunction

    // ---------------- per-cycle monitor ----------------
    logic prev_csb = 1'b1, prev_sck = 1'b0, prev_ready = 1'b0, prev_rsp = 1'b0;
    int   rises = 0, csb_low_run = 0, csb_high_run = 0;
    int   last_low_len = 0, last_rises = 0, last_lat = 0, gap_at_ready = 0;
    int   acc_cyc = 0, last_acc = 0, n_acc = 0;
    logic [31:0] last_rsp = '0;
    logic [31:0] e;
    logic [3:0]  oe_exp;

    always @(negedge sysclk) begin
        check32("no_contention", {31'd0, f_drive && (qspi_oe != 4'h0)}, 32'd0);
        check32("sck_idle_low", {31'd0, qspi_csb && qspi_sck}, 32'd0);
        check32("ready_low_while_active", {31'd0, req_ready && !qspi_csb}, 32'd0);

        if (!qspi_csb && prev_csb) begin
            rises = 0;
            csb_low_run = 0;
        end
        if (!qspi_csb) begin
            csb_low_run++;
            if (qspi_sck && !prev_sck) rises++;
            oe_exp = (rises > 8 || (rises == 8 && !qspi_sck)) ? 4'h0 : 4'hF;
            check32("oe_phase", {28'd0, qspi_oe}, {28'd0, oe_exp});
        end
        if (qspi_csb && !prev_csb) begin
            last_low_len = csb_low_run;
            last_rises = rises;
            csb_high_run = 0;
        end
        if (qspi_csb) csb_high_run++;
        if (req_ready && !prev_ready) gap_at_ready = csb_high_run - 1;

        if (req_valid && req_ready) begin
            if (n_acc > 0) check32("accept_gap_ok", {31'd0, (cyc - last_acc) >= CSBH + 1}, 32'd1);
            acc_cyc = cyc;
            last_acc = cyc;
            n_acc++;
            exp_q.push_back(exp_word(req_addr, req_size));
        end

        if (rsp_valid) begin
            last_lat = cyc - acc_cyc;
            last_rsp = rsp_data;
            rsp_hist.push_back(rsp_data);
            check32("rsp_single_pulse", {31'd0, prev_rsp}, 32'd0);
            check32("rsp_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check32("rsp_data", rsp_data, e);
            end
        end

        prev_csb = qspi_csb;
        prev_sck = qspi_sck;
        prev_ready = req_ready;
        prev_rsp = rsp_valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_req(input logic [23:0] a, input logic [1:0] s, input bit hold);
        bit ok;
        ok = 1'b0;
        req_addr = a;
        req_size = s;
        req_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge sysclk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check32("accept_timeout", {31'd0, ok}, 32'd1);
        @(posedge sysclk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge sysclk);
            if (exp_q.size() == 0 && req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check32("done_timeout", {31'd0, ok}, 32'd1);
        @(posedge sysclk);
        #1;
    endtask

    logic [31:0] exp_nibs;
    int rsp_before;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
        mem[16] = 8'h20;

        // Reset state
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        check32("rst_csb", {31'd0, qspi_csb}, 32'd1);
        check32("rst_sck", {31'd0, qspi_sck}, 32'd0);
        check32("rst_oe", {28'd0, qspi_oe}, 32'd0);
        check32("rst_dout", {28'd0, qspi_dout}, 32'd0);
        check32("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check32("rst_rsp_data", rsp_data, 32'd0);
        check32("rst_ready", {31'd0, req_ready}, 32'd0);
        @(posedge sysclk);
        #1 sysrst = 1'b0;
        @(negedge sysclk);
        check32("ready_after_rst", {31'd0, req_ready}, 32'd1);
        @(posedge sysclk);
        #1;

        // 4-byte aligned read
        do_req(24'h000004, 2'd2, 1'b0);
        wait_done();
        check32("rd4_data", last_rsp, 32'h17161514);
        check32("rd4_sck_rises", last_rises, 32'd26);
        check32("rd4_csb_low", last_low_len, 32'd52);
        check32("rd4_latency", last_lat, 32'd53);
        check32("rd4_csb_gap_ok", {31'd0, gap_at_ready >= CSBH}, 32'd1);

        // Command/address nibbles, single byte
        do_req(24'hA5C3E1, 2'd0, 1'b0);
        wait_done();
        exp_nibs = 32'hEBA5C3E1;
        for (int i = 0; i < 8; i++) begin
            check32("cmd_addr_nibble", {28'd0, cap_dout[i]}, {28'd0, exp_nibs[31-4*i -: 4]});
            check32("cmd_addr_oe", {28'd0, cap_oe[i]}, 32'hF);
        end
        check32("flash_cmd", {24'd0, f_cmd}, 32'hEB);
        check32("flash_addr", {8'd0, f_addr}, 32'hA5C3E1);
        check32("rd1_upper_zero", {8'd0, last_rsp[31:8]}, 32'd0);
        check32("rd1_data", last_rsp, 32'h000000BB);
        check32("rd1_sck_rises", last_rises, 32'd20);
        check32("rd1_latency", last_lat, 32'd41);

        // 2-byte unaligned read
        do_req(24'h00000F, 2'd1, 1'b0);
        wait_done();
        check32("rd2_data", last_rsp, 32'h0000201F);
        check32("rd2_csb_low", last_low_len, 32'd44);

        // Back-to-back with req_valid held high
        rsp_before = rsp_hist.size();
        do_req(24'h000000, 2'd0, 1'b1);
        do_req(24'h000001, 2'd0, 1'b0);
        wait_done();
        check32("b2b_count", rsp_hist.size() - rsp_before, 32'd2);
        if (rsp_hist.size() >= 2) begin
            check32("b2b_first", rsp_hist[rsp_hist.size()-2], 32'h10);
            check32("b2b_second", rsp_hist[rsp_hist.size()-1], 32'h11);
        end

        // Reset in the middle of the data phase
        rsp_before = rsp_hist.size();
        do_req(24'h000000, 2'd2, 1'b0);
        repeat (39) @(posedge sysclk);
        #1 sysrst = 1'b1;
        exp_q.delete();
        @(negedge sysclk);
        check32("midrst_ready_low", {31'd0, req_ready}, 32'd0);
        @(posedge sysclk);
        #1 sysrst = 1'b0;
        @(negedge sysclk);
        check32("midrst_csb", {31'd0, qspi_csb}, 32'd1);
        check32("midrst_oe", {28'd0, qspi_oe}, 32'd0);
        check32("midrst_sck", {31'd0, qspi_sck}, 32'd0);
        check32("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        repeat (60) @(negedge sysclk);
        check32("midrst_no_late_rsp", rsp_hist.size() - rsp_before, 32'd0);
        @(posedge sysclk);
        #1;
        do_req(24'h000008, 2'd2, 1'b0);
        wait_done();
        check32("post_rst_data", last_rsp, 32'h1B1A1918);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
